// File: rtl/cdec8_mem_loader.sv
// Program loader for an 8-bit CPU: a 256x8 memory filled over a byte stream,
// after which the CPU is released from reset and may read and write it.
module cdec8_mem_loader (
    input  logic       clock,
    input  logic       reset_N,
    input  logic [7:0] adrs,
    input  logic [7:0] wdata,
    input  logic       mmwr_en,
    output logic [7:0] rdata,
    input  logic       endseq,
    output logic       cpu_reset_N,
    input  logic       ld_start,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    output logic [7:0] ld_count,
    output logic       ld_ovf,
    output logic [1:0] state_o,
    input  logic [7:0] dbg_ad,
    output logic [7:0] dbg_dt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [7:0] r_ptr;
    logic [7:0] r_count;
    logic       r_ovf;
    logic       r_cpu_rst_n;
    logic [7:0] r_mem [0:255];

    logic       w_ld_ready;
    logic       w_accept;
    logic       w_load_entry;
    logic       w_cpu_wr;

    assign w_accept     = w_ld_ready & ld_valid;
    assign w_load_entry = (r_state != ST_LOAD) & ld_start;
    assign w_cpu_wr     = (r_state == ST_RUN) & mmwr_en;

    // State register
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; ld_start outranks endseq in RUN
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (ld_start) w_next_state = ST_LOAD;
            ST_LOAD: if (w_accept && ld_last) w_next_state = ST_RUN;
            ST_RUN: begin
                if (ld_start) begin
                    w_next_state = ST_LOAD;
                end else if (endseq) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: if (ld_start) w_next_state = ST_LOAD;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_ld_ready = 1'b0;
        if (r_state == ST_LOAD) begin
            w_ld_ready = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            r_ptr   <= 8'd0;
            r_count <= 8'd0;
            r_ovf   <= 1'b0;
        end else if (w_load_entry) begin
            r_ptr   <= 8'd0;
            r_count <= 8'd0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_ptr   <= r_ptr + 8'd1;
            r_count <= r_count + 8'd1;
            if ((r_ptr == 8'hFF) && !ld_last) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // CPU reset follows the state one cycle late, so it releases the cycle after RUN is entered
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_cpu_rst_n <= (r_state == ST_RUN) || (r_state == ST_DONE);
        end
    end

    // Memory has no reset so loaded bytes survive an aborted load
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_mem[r_ptr] <= ld_data;
        end else if (w_cpu_wr) begin
            r_mem[adrs] <= wdata;
        end
    end

    assign rdata       = r_mem[adrs];
    assign dbg_dt      = r_mem[dbg_ad];
    assign cpu_reset_N = r_cpu_rst_n;
    assign ld_ready    = w_ld_ready;
    assign ld_count    = r_count;
    assign ld_ovf      = r_ovf;
    assign state_o     = r_state;

endmodule

// File: tb/tb_cdec8_mem_loader.sv
// Directed self-checking bench for cdec8_mem_loader: load, stall, overflow,
// CPU write gating, state transitions and mid-load reset.
module tb_cdec8_mem_loader;

    logic       clock = 1'b0;
    logic       reset_N;
    logic [7:0] adrs;
    logic [7:0] wdata;
    logic       mmwr_en;
    logic [7:0] rdata;
    logic       endseq;
    logic       cpu_reset_N;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic [7:0] ld_count;
    logic       ld_ovf;
    logic [1:0] state_o;
    logic [7:0] dbg_ad;
    logic [7:0] dbg_dt;

    int n_checks = 0;
    int n_errors = 0;

    cdec8_mem_loader dut (
        .clock      (clock),
        .reset_N    (reset_N),
        .adrs       (adrs),
        .wdata      (wdata),
        .mmwr_en    (mmwr_en),
        .rdata      (rdata),
        .endseq     (endseq),
        .cpu_reset_N(cpu_reset_N),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ld_count   (ld_count),
        .ld_ovf     (ld_ovf),
        .state_o    (state_o),
        .dbg_ad     (dbg_ad),
        .dbg_dt     (dbg_dt)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic peek(input string tag, input logic [7:0] a, input logic [7:0] exp);
        dbg_ad = a;
        #1;
        chk(tag, dbg_dt, exp);
    endtask

    initial begin
        reset_N  = 1'b1;
        adrs     = 8'h00;
        wdata    = 8'h00;
        mmwr_en  = 1'b0;
        endseq   = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        ld_last  = 1'b0;
        dbg_ad   = 8'h00;
        #1 reset_N = 1'b0;
        #1;
        chk("rst_state", {6'd0, state_o}, 8'd0);
        chk("rst_cpu", {7'd0, cpu_reset_N}, 8'd0);
        chk("rst_ready", {7'd0, ld_ready}, 8'd0);
        chk("rst_count", ld_count, 8'd0);
        chk("rst_ovf", {7'd0, ld_ovf}, 8'd0);
        step();
        reset_N = 1'b1;
        step();
        step();
        chk("idle_hold", {6'd0, state_o}, 8'd0);
        chk("idle_cpu", {7'd0, cpu_reset_N}, 8'd0);

        // Basic load with a 5-cycle stall and an ignored ld_start
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("load_state", {6'd0, state_o}, 8'd1);
        chk("load_ready", {7'd0, ld_ready}, 8'd1);
        chk("load_cpu", {7'd0, cpu_reset_N}, 8'd0);
        ld_valid = 1'b1; ld_data = 8'h11;
        step();
        ld_data = 8'h22;
        step();
        chk("cnt2", ld_count, 8'd2);
        ld_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_start = (i == 2);
            step();
        end
        ld_start = 1'b0;
        chk("stall_cnt", ld_count, 8'd2);
        chk("stall_state", {6'd0, state_o}, 8'd1);
        ld_valid = 1'b1; ld_data = 8'h33; ld_last = 1'b1;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("run_state", {6'd0, state_o}, 8'd2);
        chk("run_cnt3", ld_count, 8'd3);
        chk("run_cpu_lag", {7'd0, cpu_reset_N}, 8'd0);
        chk("run_ready", {7'd0, ld_ready}, 8'd0);
        step();
        chk("run_cpu", {7'd0, cpu_reset_N}, 8'd1);
        peek("mem0", 8'h00, 8'h11);
        peek("mem1", 8'h01, 8'h22);
        peek("mem2", 8'h02, 8'h33);

        // CPU write in RUN lands; in DONE it is blocked
        adrs = 8'h80; wdata = 8'h5C; mmwr_en = 1'b1;
        step();
        mmwr_en = 1'b0;
        peek("run_wr_dbg", 8'h80, 8'h5C);
        chk("run_wr_rdata", rdata, 8'h5C);
        endseq = 1'b1;
        step();
        endseq = 1'b0;
        chk("done_state", {6'd0, state_o}, 8'd3);
        chk("done_cpu", {7'd0, cpu_reset_N}, 8'd1);
        chk("done_cnt_hold", ld_count, 8'd3);
        wdata = 8'hEE; mmwr_en = 1'b1;
        step();
        mmwr_en = 1'b0;
        peek("done_wr_blk", 8'h80, 8'h5C);

        // Reload from DONE; CPU writes during LOAD are blocked
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("reload_state", {6'd0, state_o}, 8'd1);
        chk("reload_cnt_clr", ld_count, 8'd0);
        step();
        chk("reload_cpu", {7'd0, cpu_reset_N}, 8'd0);
        wdata = 8'h99; mmwr_en = 1'b1;
        step();
        mmwr_en = 1'b0;
        peek("load_wr_blk", 8'h80, 8'h5C);

        // 257-byte load wraps the pointer and sets the sticky overflow
        ld_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ld_data = 8'(i);
            step();
        end
        chk("wrap_ovf", {7'd0, ld_ovf}, 8'd1);
        chk("wrap_cnt0", ld_count, 8'd0);
        ld_data = 8'hAA; ld_last = 1'b1;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("ovf_state", {6'd0, state_o}, 8'd2);
        chk("ovf_cnt1", ld_count, 8'd1);
        chk("ovf_flag", {7'd0, ld_ovf}, 8'd1);
        peek("ovf_mem0", 8'h00, 8'hAA);
        peek("ovf_mem1", 8'h01, 8'h01);
        peek("ovf_memff", 8'hFF, 8'hFF);
        step();
        chk("ovf_run_cpu", {7'd0, cpu_reset_N}, 8'd1);

        // ld_start beats endseq in RUN
        ld_start = 1'b1; endseq = 1'b1;
        step();
        ld_start = 1'b0; endseq = 1'b0;
        chk("prio_state", {6'd0, state_o}, 8'd1);
        chk("prio_ovf_clr", {7'd0, ld_ovf}, 8'd0);
        step();
        chk("prio_cpu", {7'd0, cpu_reset_N}, 8'd0);

        // Reset after 2 of 4 bytes aborts the load but keeps the bytes
        ld_valid = 1'b1; ld_data = 8'hC1;
        step();
        ld_data = 8'hC2;
        step();
        ld_valid = 1'b0;
        reset_N = 1'b0;
        #1;
        chk("abort_state", {6'd0, state_o}, 8'd0);
        chk("abort_cpu", {7'd0, cpu_reset_N}, 8'd0);
        chk("abort_cnt", ld_count, 8'd0);
        step();
        reset_N = 1'b1;
        step();
        chk("abort_idle", {6'd0, state_o}, 8'd0);
        peek("abort_mem0", 8'h00, 8'hC1);
        peek("abort_mem1", 8'h01, 8'hC2);
        adrs = 8'h01;
        #1;
        chk("abort_rdata", rdata, 8'hC2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cdec8_mem_loader.md
CDEC8_MEM_LOADER -- requirements
Module: cdec8_mem_loader

Interface
REQ-001 SHALL have port: clock  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset_N  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: adrs  input  8  CPU memory address.
REQ-004 SHALL have port: wdata  input  8  CPU write data (CPU data_out).
REQ-005 SHALL have port: mmwr_en  input  1  CPU write strobe.
REQ-006 SHALL have port: rdata  output  8  CPU read data (CPU data_in).
REQ-007 SHALL have port: endseq  input  1  CPU end-of-program indication.
REQ-008 SHALL have port: cpu_reset_N  output  1  registered active-low reset to CPU.
REQ-009 SHALL have port: ld_start  input  1  load request pulse.
REQ-010 SHALL have port: ld_valid  input  1  load byte valid.
REQ-011 SHALL have port: ld_data  input  8  load byte.
REQ-012 SHALL have port: ld_last  input  1  marks final load byte, qualified by ld_valid.
REQ-013 SHALL have port: ld_ready  output  1  loader accepts a byte this cycle.
REQ-014 SHALL have port: ld_count  output  8  number of bytes accepted in current/last load, mod 256.
REQ-015 SHALL have port: ld_ovf  output  1  sticky: load wrapped past address 255.
REQ-016 SHALL have port: state_o  output  2  current state: IDLE=0, LOAD=1, RUN=2, DONE=3.
REQ-017 SHALL have port: dbg_ad  input  8  debug read address.
REQ-018 SHALL have port: dbg_dt  output  8  debug read data.

Function
REQ-019 SHALL contain a 256 x 8 memory; contents not initialised or cleared by reset.
REQ-020 rdata SHALL equal mem[adrs] combinationally (zero-cycle read); dbg_dt SHALL equal mem[dbg_ad] combinationally, in every state.
REQ-021 CPU write: in RUN only, mmwr_en=1 at a rising edge SHALL write wdata to mem[adrs]; ignored in IDLE, LOAD, DONE.
REQ-022 State IDLE: cpu_reset_N=0, ld_ready=0; ld_start=1 -> LOAD.
REQ-023 Entry to LOAD SHALL clear the write pointer, ld_count and ld_ovf.
REQ-024 State LOAD: ld_ready=1, cpu_reset_N=0; handshake accept when ld_valid and ld_ready both 1 at a rising edge.
REQ-025 On accept SHALL write ld_data to mem[ptr], then ptr and ld_count increment by 1 mod 256.
REQ-026 Accept with ptr=255 and ld_last=0 SHALL set ld_ovf=1 and wrap ptr to 0; loading continues.
REQ-027 Accept with ld_last=1 SHALL write that byte, then -> RUN on the same edge.
REQ-028 ld_valid=0 in LOAD SHALL hold state, ptr and memory unchanged (stall, no timeout).
REQ-029 ld_start in LOAD SHALL be ignored, with no pointer restart.
REQ-030 State RUN: cpu_reset_N=1 (registered, asserted the first cycle after the edge entering RUN), ld_ready=0.
REQ-031 In RUN, endseq=1 -> DONE.
REQ-032 In RUN or DONE, ld_start=1 -> LOAD, and cpu_reset_N=0 on the next cycle.
REQ-033 ld_start has priority over endseq when both are 1 in RUN.
REQ-034 State DONE: cpu_reset_N=1 (CPU held, memory frozen against CPU writes), ld_ready=0; the memory remains readable via rdata and dbg_dt.
REQ-035 ld_count and ld_ovf SHALL hold their values outside LOAD.

Reset
REQ-036 reset_N=0 SHALL immediately force: state IDLE, cpu_reset_N=0, ld_ready=0, ld_count=0, ld_ovf=0, ptr=0.
REQ-037 Reset asserted mid-LOAD SHALL abort the load; bytes already written remain in memory.
REQ-038 Reset release SHALL leave the block in IDLE until ld_start.

Verification
REQ-039 Reset, ld_start, then bytes 0x11,0x22,0x33 with ld_last on 0x33 -> mem[0..2]=11,22,33; ld_count=3; RUN; cpu_reset_N=1 one cycle later.
REQ-040 During LOAD drop ld_valid for 5 cycles mid-stream -> no writes, ld_count unchanged, load resumes at next address.
REQ-041 257 bytes with ld_last on the 257th (value 0xAA) -> ld_ovf=1, ld_count=1, mem[0]=0xAA, RUN.
REQ-042 In RUN, CPU writes 0x5C at adrs 0x80 -> dbg_ad=0x80 gives dbg_dt=0x5C; the same write during LOAD or DONE leaves mem[0x80] unchanged.
REQ-043 endseq in RUN -> DONE; ld_start and endseq together in RUN -> LOAD, cpu_reset_N=0.
REQ-044 reset_N pulsed low after 2 of 4 load bytes -> IDLE, cpu_reset_N=0, ld_count=0, mem[0..1] retain the loaded values.
